// File: rtl/nibble_word_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : nibble_word_packer
// Description : Packs shifter nibbles LSB-first into words, queued in a
//               2-entry FIFO; words arriving while it is full are dropped.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module nibble_word_packer #(
    parameter int NIB_W  = 4,
    parameter int NIBS   = 4,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [NIB_W-1:0]       in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W*NIBS-1:0]  out_data,
    output logic                   out_partial,
    output logic [1:0]             fill,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int c_WORD_W = NIB_W * NIBS;
    localparam int c_IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBS - 1);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [c_WORD_W-1:0] r_acc;
    logic [c_IDX_W-1:0]  r_idx;

    logic [1:0]          r_state;
    logic                r_valid;
    logic [1:0]          r_fill;
    logic [c_WORD_W-1:0] r_head;
    logic                r_head_partial;
    logic [c_WORD_W-1:0] r_tail;
    logic                r_tail_partial;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_count;

    logic [c_WORD_W-1:0] w_acc_next;
    logic                w_complete;
    logic                w_push;
    logic                w_push_partial;
    logic                w_pop;
    logic                w_drop;

    // The incoming nibble lands in the slot selected by the current index.
    for (genvar k = 0; k < NIBS; k++) begin : g_slot
        assign w_acc_next[k*NIB_W +: NIB_W] =
            (in_valid && (r_idx == c_IDX_W'(k))) ? in_data : r_acc[k*NIB_W +: NIB_W];
    end

    assign w_complete     = in_valid && (r_idx == c_LAST_IDX);
    assign w_push         = w_complete || (flush && ((r_idx != '0) || in_valid));
    assign w_push_partial = !w_complete;
    assign w_pop          = r_valid && out_ready;
    assign w_drop         = w_push && !w_pop && (r_state == c_ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_push) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (in_valid) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + 1'b1;
        end
    end

    // Head register drives the outputs directly; tail only holds the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_EMPTY;
            r_valid        <= 1'b0;
            r_fill         <= 2'd0;
            r_head         <= '0;
            r_head_partial <= 1'b0;
            r_tail         <= '0;
            r_tail_partial <= 1'b0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_push) begin
                        r_head         <= w_acc_next;
                        r_head_partial <= w_push_partial;
                        r_state        <= c_ST_ONE;
                        r_valid        <= 1'b1;
                        r_fill         <= 2'd1;
                    end
                end
                c_ST_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_tail         <= w_acc_next;
                            r_tail_partial <= w_push_partial;
                            r_state        <= c_ST_FULL;
                            r_fill         <= 2'd2;
                        end
                        2'b01: begin
                            r_head         <= '0;
                            r_head_partial <= 1'b0;
                            r_state        <= c_ST_EMPTY;
                            r_valid        <= 1'b0;
                            r_fill         <= 2'd0;
                        end
                        2'b11: begin
                            r_head         <= w_acc_next;
                            r_head_partial <= w_push_partial;
                        end
                        default: ;
                    endcase
                end
                c_ST_FULL: begin
                    case ({w_push, w_pop})
                        2'b01: begin
                            r_head         <= r_tail;
                            r_head_partial <= r_tail_partial;
                            r_tail         <= '0;
                            r_tail_partial <= 1'b0;
                            r_state        <= c_ST_ONE;
                            r_fill         <= 2'd1;
                        end
                        2'b11: begin
                            r_head         <= r_tail;
                            r_head_partial <= r_tail_partial;
                            r_tail         <= w_acc_next;
                            r_tail_partial <= w_push_partial;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    r_state        <= c_ST_EMPTY;
                    r_valid        <= 1'b0;
                    r_fill         <= 2'd0;
                    r_head         <= '0;
                    r_head_partial <= 1'b0;
                    r_tail         <= '0;
                    r_tail_partial <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_head;
    assign out_partial = r_head_partial;
    assign fill        = r_fill;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: doc/nibble_word_packer.md
# nibble_word_packer

Downstream stage of the 4-bit right shifter. Collects the shifter's 4-bit output nibbles into 16-bit words and hands them to a consumer over a valid/ready interface. A 2-entry output FIFO absorbs consumer stalls. Because the shifter has no back-pressure, words that arrive while the FIFO is full are dropped and counted.

## Interface
- NIB_W, 4, nibble width; must match the shifter data width.
- NIBS, 4, nibbles per output word; output width is NIB_W*NIBS = 16.
- DROP_W, 8, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data holds a nibble this cycle.
- in_data  in  NIB_W  nibble from the shifter's dout.
- flush  in  1  emit the partial word now, zero-padded.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  NIB_W*NIBS  FIFO head word.
- out_partial  out  1  head word was produced by flush, not by a full count.
- fill  out  2  FIFO occupancy, 0..2.
- overflow  out  1  sticky; set on the first dropped word.
- drop_count  out  DROP_W  number of dropped words; saturates at all-ones.

## Operation
- Reset values: out_valid=0, out_data=0, out_partial=0, fill=0, overflow=0, drop_count=0. Reset also sets the accumulator to 0 and the nibble index to 0.
- Input is accepted on every cycle where in_valid=1. There is no input ready signal.
- Nibble k (k=0..NIBS-1) is written to accumulator bits [NIB_W*k+NIB_W-1 : NIB_W*k]. Nibbles are packed LSB-first.
- Word complete: a nibble is accepted at index NIBS-1. The word, including that nibble, is pushed to the FIFO with partial=0. The index wraps to 0 and the accumulator clears to 0.
- Flush when the index is greater than 0 or in_valid=1:
  - The same-cycle nibble, if any, is included first.
  - The word is pushed with unfilled slots equal to 0 and partial=1.
  - Exception: if that nibble completes the word, partial=0.
  - The index is reset to 0.
- Flush with index=0 and in_valid=0 is a no-op; no word is pushed.
- The FIFO uses 3 states:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push with pop -> ONE.
  - FULL: pop -> ONE; push with pop -> FULL, and the word is accepted.
- A pop happens when out_valid=1 and out_ready=1.
- Push while FULL with no pop in the same cycle:
  - The word is dropped and the FIFO is unchanged.
  - overflow is set to 1.
  - drop_count increments, saturating at all-ones.
  - The accumulator and index still clear and wrap as usual.
- overflow and drop_count clear only on rst.
- out_data and out_partial hold their value while out_valid=1 and out_ready=0. Both are 0 whenever fill=0.

## Timing
- Latency: the word appears on out_valid/out_data on the cycle after the completing (or flushing) input cycle.
- Throughput: at most 1 word per NIBS cycles from full words, and at most 1 word per cycle when flushing. The FIFO sustains 1 push and 1 pop per cycle.
- Pop is registered: the next head, or out_valid=0, appears on the cycle after the handshake.
- fill, overflow and drop_count update on the same edge as the push or pop that changes them.
- rst asserted mid-word or with a non-empty FIFO discards everything; all outputs take their reset values on the next edge.
- When rst and in_valid are both high in the same cycle, the nibble is ignored.

## Test plan
- Free-running consumer: out_ready=1; feed nibbles 1,2,4,8 on consecutive cycles -> one cycle after the 4th nibble, out_valid=1, out_data=16'h8421, out_partial=0; fill returns to 0 after the pop.
- Stalled consumer: out_ready=0; feed 12 nibbles 0..B -> FIFO holds 16'h3210 and 16'h7654. The third word (16'hBA98) is dropped: overflow=1, drop_count=1, fill=2. Then raise out_ready -> 16'h3210 pops, then 16'h7654.
- Flush: feed nibbles 5,A, then pulse flush with in_valid=0 -> out_data=16'h00A5, out_partial=1. The next 4 nibbles pack from index 0.
- Flush on a completing nibble: feed 1,2,3, then nibble 4 with flush=1 in the same cycle -> a single word 16'h4321 with out_partial=0; no extra word is produced.
- Push and pop while full: fill=2 and out_ready=1 in the same cycle a word completes -> no drop; fill stays 2; drop_count is unchanged.
- Reset mid-operation: with fill=1 and index=2, assert rst for one cycle -> all outputs 0. Then feed nibbles F,F,F,F -> 16'hFFFF, with no leftover nibbles from before the reset.
